serial_cmp_ctrl: RTL
====================

# serial_cmp_ctrl

Sequencer that performs a WIDTH-bit magnitude comparison by stepping a 1-bit comparator slice through the operands, starting at the MSB. The slice computes lt = ~a&b, eq = (a&b)|(~a&~b) and gt = a&~b. The block latches both operands on a start handshake and shifts them one bit per cycle. It exits on the first differing bit and reports a one-hot lt/eq/gt result with a done pulse. It sits between a requesting datapath and the shared 1-bit compare slice, so wide compares can reuse that slice without a parallel comparator.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; must be 2 or greater.
- EARLY_EXIT, 1: when 1, stop at the first differing bit; when 0, always take WIDTH cycles for constant latency.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A (unsigned); captured on an accepted start.
- b  input  WIDTH  operand B (unsigned); captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- lt  output  1  A < B.
- eq  output  1  A == B.
- gt  output  1  A > B.
- bits  output  $clog2(WIDTH+1)  number of bit positions examined in the last compare.

## Operation
States:
- IDLE (reset state): busy=0.
  - start=1 → capture a and b into shift registers, clear the position counter, clear the sticky-diff flag, go to RUN.
- RUN: busy=1. Each cycle:
  - Apply the current MSBs of the shift registers to the 1-bit slice.
  - Shift both registers left by 1 and increment the counter.
  - Slice gt=1 or lt=1, with sticky-diff clear → record that result and set sticky-diff.
  - EARLY_EXIT=1 with a difference found, or the counter reaching WIDTH-1 → go to DONE.
- DONE: busy=0, done=1 for exactly this cycle, then go to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE and goes to RUN. The done pulse is still emitted in that cycle.

Result and counter rules:
- All positions equal → eq=1, lt=0, gt=0.
- Otherwise the first (most significant) differing bit decides lt or gt.
  - Later bits never override it; this matters when EARLY_EXIT=0.
- lt/eq/gt/bits update only at the edge that enters DONE. They hold until the next compare completes and are not cleared on start.
- bits equals the 1-based index, counted from the MSB, of the deciding bit when EARLY_EXIT=1 and a difference exists; otherwise it equals WIDTH.

Boundary conditions:
- start while busy=1 is ignored; the operands are not recaptured.
- Changes on a and b after capture have no effect.
- rst_n low at any time, including mid-RUN, immediately forces IDLE and all outputs to reset values. The aborted compare produces no done.

## Timing
- Reset values: busy=0, done=0, lt=0, eq=0, gt=0, bits=0, state IDLE.
- start is accepted at edge E0; busy is high from E0.
- The bit at position p (p=0 is the MSB) is evaluated between E_p and E_(p+1).
- Latency with EARLY_EXIT=1 and first difference at p: results register at E_(p+1), and done is high in the cycle after E_(p+1).
- Latency for an equal compare, or any compare with EARLY_EXIT=0: results register at E_WIDTH, and done is high after E_WIDTH.
- Minimum start-to-start interval is latency+1 cycles. Back-to-back operation is possible by asserting start during the DONE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, EARLY_EXIT=1, a=0x80, b=0x7F, 1-cycle start → gt=1, lt=0, eq=0, bits=1; done 1 cycle after the accept edge; busy high for 1 cycle.
- a=0x12, b=0x13 → lt=1, bits=8, done after 8 cycles. Then a=0x5A, b=0x5A → eq=1, bits=8. Then a=0x00, b=0xFF → lt=1, bits=1.
- EARLY_EXIT=0, a=0x80, b=0x01 → gt=1 (the LSB difference does not override), bits=8, done exactly 8 cycles after the accept edge.
- Handshake: start at E0 with a=0x40, b=0x00; at E0+1 drive start=1 with a=0x00, b=0x40 → the second start is ignored, result gt=1, bits=2. Then assert start in the DONE cycle with a=0x03, b=0x03 → a new compare begins at that edge and ends with eq=1.
- Reset mid-op: pull rst_n low 3 cycles into a compare of 0x01 vs 0x02 → all outputs 0 immediately and no done. After release, a new compare of 0x01 vs 0x02 completes with lt=1, bits=7.
- Exhaustive WIDTH=2 sweep of all 16 (a,b) pairs → exactly one of lt/eq/gt is set, and it matches the unsigned reference compare.

Source files
------------

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator sequencer: walks a 1-bit compare slice from MSB to LSB
// over two latched operands and reports a one-hot lt/eq/gt result with a done pulse.
module serial_cmp_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       lt,
    output logic                       eq,
    output logic                       gt,
    output logic [$clog2(WIDTH+1)-1:0] bits
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Shared compare slice, packed as {lt, eq, gt}
    function automatic logic [2:0] slice_cmp(input logic a_bit, input logic b_bit);
        slice_cmp = {~a_bit & b_bit, (a_bit & b_bit) | (~a_bit & ~b_bit), a_bit & ~b_bit};
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_sticky;
    logic             r_rec_lt;
    logic             r_rec_gt;
    logic             r_busy;
    logic             r_done;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic [CW-1:0]    r_bits;

    logic [2:0]       w_slice;
    logic             w_diff;
    logic             w_accept;
    logic             w_exit;
    logic             w_res_lt;
    logic             w_res_gt;

    assign w_slice  = slice_cmp(r_a[WIDTH-1], r_b[WIDTH-1]);
    assign w_diff   = ~w_slice[1];
    assign w_accept = start & (r_state != S_RUN);

    // The first differing bit wins; later differences never override it
    assign w_res_lt = r_sticky ? r_rec_lt : w_slice[2];
    assign w_res_gt = r_sticky ? r_rec_gt : w_slice[0];

    // Next-state decode and exit detection
    always_comb begin
        w_next = r_state;
        w_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if ((EARLY_EXIT && w_diff) || (r_cnt == CW'(WIDTH-1))) begin
                    w_next = S_DONE;
                    w_exit = 1'b1;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Operand shifting, position counter and sticky first-difference capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_sticky <= 1'b0;
            r_rec_lt <= 1'b0;
            r_rec_gt <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_cnt    <= {CW{1'b0}};
            r_sticky <= 1'b0;
            r_rec_lt <= 1'b0;
            r_rec_gt <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_a   <= {r_a[WIDTH-2:0], 1'b0};
            r_b   <= {r_b[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
            if (!r_sticky && w_diff) begin
                r_sticky <= 1'b1;
                r_rec_lt <= w_slice[2];
                r_rec_gt <= w_slice[0];
            end
        end
    end

    // Result registers change only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lt   <= 1'b0;
            r_eq   <= 1'b0;
            r_gt   <= 1'b0;
            r_bits <= {CW{1'b0}};
        end else if (w_exit) begin
            r_lt   <= w_res_lt;
            r_eq   <= ~(w_res_lt | w_res_gt);
            r_gt   <= w_res_gt;
            r_bits <= r_cnt + CW'(1);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign lt   = r_lt;
    assign eq   = r_eq;
    assign gt   = r_gt;
    assign bits = r_bits;
endmodule
